// File: rtl/sd_sector_wbwriter_if.sv
// Wishbone classic write port between sd_sector_wbwriter and one arbitrated
// slave port (wb2..wb5) of the shared 8 KB block RAM.
interface sd_sector_wbwriter_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;

    // Writer side: drives the cycle, receives the acknowledge
    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_ack_i
    );

    // RAM port side
    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_ack_i
    );
endinterface

// File: rtl/sd_sector_wbwriter.sv
// sd_sector_wbwriter: packs an SD receive byte stream little-endian into
// 32-bit words and writes one sector to block RAM with single classic
// Wishbone writes. A two-deep buffer (pack + hold) lets the stream keep
// running while a write waits for its acknowledge.
// Optional feature macro: SDWR_CRC16_EN adds crc_o, the CRC16-CCITT of the
// accepted sector bytes, published when done_o pulses.
module sd_sector_wbwriter #(
    parameter int SECTOR_BYTES = 512,
    parameter int ADR_WRAP     = 8192
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start_i,
    input  logic [31:0] base_adr_i,
    input  logic        abort_i,
    input  logic [7:0]  byte_dat_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
`ifdef SDWR_CRC16_EN
    output logic [15:0] crc_o,
`endif
    sd_sector_wbwriter_if.master wb
);

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_RUN     = 2'd1;
    localparam logic [1:0]  ST_DRAIN   = 2'd2;
    localparam logic [11:0] LAST_CNT   = 12'(SECTOR_BYTES - 1);
    localparam logic [12:0] SECTOR_LEN = 13'(SECTOR_BYTES);
    localparam logic [29:0] WRAP_WORDS = 30'(ADR_WRAP / 4);

    logic [1:0]  state_q;
    logic [11:0] cnt_q;
    logic [31:0] adr_q;
    logic [31:0] pack_q;
    logic [31:0] hold_q;
    logic        pack_full_q;
    logic        hold_vld_q;
    logic        cyc_q;
    logic        abort_pend_q;
    logic        done_q;
    logic        err_q;

    logic        active;
    logic        byte_fire;
    logic        word_done;
    logic [31:0] word_new;
    logic        ack_fire;
    logic        hold_free;
    logic        abort_now;
    logic        finish_err;
    logic        finish_done;
    logic [29:0] adr_inc;
    logic [31:0] adr_next;

    // Handshake and transition qualifiers derived from the registered state
    always_comb begin
        active       = (state_q != ST_IDLE);
        byte_ready_o = (state_q == ST_RUN) && !abort_pend_q
                       && !(pack_full_q && hold_vld_q)
                       && ({1'b0, cnt_q} < SECTOR_LEN);
        byte_fire    = byte_ready_o && byte_valid_i;
        word_done    = byte_fire && (cnt_q[1:0] == 2'b11);
        word_new     = {byte_dat_i, pack_q[23:0]};
        ack_fire     = cyc_q && wb.wb_ack_i;
        hold_free    = !hold_vld_q || ack_fire;
        // A pending abort only completes once no write is left on the bus
        abort_now    = active && (abort_i || abort_pend_q);
        finish_err   = abort_now && (!cyc_q || ack_fire);
        finish_done  = (state_q == ST_DRAIN) && ack_fire && !pack_full_q && !finish_err;
        adr_inc      = adr_q[31:2] + 30'd1;
        adr_next     = (adr_inc == WRAP_WORDS) ? 32'd0 : {adr_inc, 2'b00};
    end

    // Sector sequencing: byte count, abort bookkeeping, completion pulses
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            abort_pend_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (start_i) begin
                    state_q      <= ST_RUN;
                    cnt_q        <= '0;
                    abort_pend_q <= 1'b0;
                end
            end else if (finish_err) begin
                state_q      <= ST_IDLE;
                err_q        <= 1'b1;
                abort_pend_q <= 1'b0;
            end else begin
                if (abort_i)
                    abort_pend_q <= 1'b1;
                if (finish_done) begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end else if (byte_fire && (cnt_q == LAST_CNT)) begin
                    state_q <= ST_DRAIN;
                end
                if (byte_fire)
                    cnt_q <= cnt_q + 12'd1;
            end
        end
    end

    // Word assembly, pack-to-hold transfer and write address
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            adr_q       <= '0;
            pack_q      <= '0;
            hold_q      <= '0;
            pack_full_q <= 1'b0;
            hold_vld_q  <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (start_i) begin
                adr_q       <= base_adr_i & 32'hFFFF_FFFC;
                pack_q      <= '0;
                hold_q      <= '0;
                pack_full_q <= 1'b0;
                hold_vld_q  <= 1'b0;
            end
        end else begin
            if (ack_fire)
                adr_q <= adr_next;
            if (finish_err || finish_done) begin
                pack_full_q <= 1'b0;
                hold_vld_q  <= 1'b0;
            end else begin
                if (byte_fire)
                    pack_q[{cnt_q[1:0], 3'b000} +: 8] <= byte_dat_i;
                if (hold_free && pack_full_q) begin
                    hold_q      <= pack_q;
                    hold_vld_q  <= 1'b1;
                    pack_full_q <= 1'b0;
                end else if (word_done) begin
                    if (hold_free) begin
                        hold_q     <= word_new;
                        hold_vld_q <= 1'b1;
                    end else begin
                        pack_full_q <= 1'b1;
                    end
                end else if (ack_fire) begin
                    hold_vld_q <= 1'b0;
                end
            end
        end
    end

    // Bus cycle: raise after hold fills, drop after ack, never break a cycle
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            cyc_q <= 1'b0;
        else if (ack_fire)
            cyc_q <= 1'b0;
        else if (!cyc_q && hold_vld_q && active && !abort_now)
            cyc_q <= 1'b1;
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = hold_q;
    assign wb.wb_sel_o = 4'b1111;
    assign wb.wb_we_o  = cyc_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign busy_o      = active;
    assign done_o      = done_q;
    assign err_o       = err_q;

`ifdef SDWR_CRC16_EN
    logic [15:0] crc_run_q;
    logic [15:0] crc_q;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb)
                c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Running CRC over accepted bytes; published value changes only at done
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            crc_run_q <= '0;
            crc_q     <= '0;
        end else if ((state_q == ST_IDLE) && start_i) begin
            crc_run_q <= '0;
            crc_q     <= '0;
        end else begin
            if (byte_fire)
                crc_run_q <= crc16_byte(crc_run_q, byte_dat_i);
            if (finish_done)
                crc_q <= crc_run_q;
        end
    end

    assign crc_o = crc_q;
`endif

endmodule

// File: tb/tb_sd_sector_wbwriter.sv
// Bench for sd_sector_wbwriter: scoreboarded sector writes against a
// Wishbone slave with programmable ack delay, plus abort and reset cases.
module tb_sd_sector_wbwriter;

    localparam int SB   = 512;
    localparam int WRAP = 8192;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_adr;
    logic        abort;
    logic [7:0]  byte_dat;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic        done;
    logic        err;
`ifdef SDWR_CRC16_EN
    logic [15:0] crc;
`endif

    sd_sector_wbwriter_if wb_if();

    sd_sector_wbwriter #(.SECTOR_BYTES(SB), .ADR_WRAP(WRAP)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .start_i      (start),
        .base_adr_i   (base_adr),
        .abort_i      (abort),
        .byte_dat_i   (byte_dat),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
`ifdef SDWR_CRC16_EN
        .crc_o        (crc),
`endif
        .wb           (wb_if.master)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ack_delay = 1;
    int slv_wait = 0;
    logic slv_ack = 1'b0;
    int done_cnt = 0;
    int err_cnt  = 0;

    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];
    logic [31:0] cap_adr[$];
    logic [31:0] cap_dat[$];
    int first_stall;

    assign wb_if.wb_ack_i = slv_ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: registered ack after ack_delay cycles of cyc, one cycle wide
    always @(posedge clk) begin
        if (!wb_if.wb_cyc_o || slv_ack) begin
            slv_ack  <= 1'b0;
            slv_wait <= 0;
        end else if (slv_wait + 1 >= ack_delay) begin
            slv_ack <= 1'b1;
        end else begin
            slv_wait <= slv_wait + 1;
        end
    end

    // Pulse counters
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
    end

    function automatic logic [7:0] pat(input int mode, input int idx);
        case (mode)
            0:       return 8'(idx);
            1:       return 8'(idx * 7 + 3);
            default: return 8'hFF;
        endcase
    endfunction

    // One full sector: stream driver pushes expected words, collector pops them
    task automatic run_sector(input logic [31:0] base, input int mode, input int delay);
        int nw;
        exp_adr_q.delete(); exp_dat_q.delete();
        cap_adr.delete(); cap_dat.delete();
        first_stall = -1;
        ack_delay = delay;
        @(negedge clk);
        start = 1'b1; base_adr = base;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (byte_ready !== 1'b1 || busy !== 1'b1)
            $display("FAIL start_ready: ready=%b busy=%b, required 1/1", byte_ready, busy);
        else n_pass++;
        nw = 0;
        fork
            begin
                int idx;
                int guard;
                logic [31:0] w;
                idx = 0; guard = 0; w = '0;
                while (idx < SB && guard < 20000) begin
                    byte_valid = 1'b1;
                    byte_dat   = pat(mode, idx);
                    if (byte_ready) begin
                        w[8*(idx%4) +: 8] = byte_dat;
                        if (idx % 4 == 3) begin
                            exp_adr_q.push_back(((base & 32'hFFFF_FFFC) + 32'(4*(idx/4))) % 32'(WRAP));
                            exp_dat_q.push_back(w);
                        end
                        idx++;
                    end else if (first_stall < 0) begin
                        first_stall = idx;
                    end
                    @(negedge clk);
                    guard++;
                end
                byte_valid = 1'b0;
            end
            begin
                int guard;
                logic [31:0] ea, ed;
                guard = 0;
                while (nw < SB/4 && guard < 20000) begin
                    @(negedge clk);
                    guard++;
                    if (wb_if.wb_cyc_o && slv_ack) begin
                        ea = 32'hDEAD_BEEF; ed = 32'hDEAD_BEEF;
                        if (exp_adr_q.size() > 0) begin
                            ea = exp_adr_q.pop_front();
                            ed = exp_dat_q.pop_front();
                        end
                        n_checks++;
                        if (wb_if.wb_adr_o !== ea || wb_if.wb_dat_o !== ed || wb_if.wb_sel_o !== 4'hF
                            || wb_if.wb_we_o !== 1'b1 || wb_if.wb_stb_o !== 1'b1)
                            $display("FAIL write%0d: adr=%h dat=%h sel=%h we=%b stb=%b, required adr=%h dat=%h sel=f we=1 stb=1",
                                     nw, wb_if.wb_adr_o, wb_if.wb_dat_o, wb_if.wb_sel_o, wb_if.wb_we_o, wb_if.wb_stb_o, ea, ed);
                        else n_pass++;
                        cap_adr.push_back(wb_if.wb_adr_o);
                        cap_dat.push_back(wb_if.wb_dat_o);
                        nw++;
                    end
                end
            end
        join
        n_checks++;
        if (nw != SB/4) $display("FAIL write_count: got %0d writes, required %0d", nw, SB/4);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0)
            $display("FAIL done_after_last_ack: done=%b busy=%b err=%b, required 1/0/0", done, busy, err);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || wb_if.wb_cyc_o !== 1'b0)
            $display("FAIL done_pulse_width: done=%b cyc=%b, required 0/0", done, wb_if.wb_cyc_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wb_if.wb_cyc_o !== 1'b0 || wb_if.wb_stb_o !== 1'b0 || wb_if.wb_we_o !== 1'b0 || byte_ready !== 1'b0)
            $display("FAIL reset_ctrl: cyc=%b stb=%b we=%b ready=%b, required 0", wb_if.wb_cyc_o, wb_if.wb_stb_o, wb_if.wb_we_o, byte_ready);
        else n_pass++;
        n_checks++;
        if (wb_if.wb_adr_o !== 32'd0 || wb_if.wb_dat_o !== 32'd0 || wb_if.wb_sel_o !== 4'hF)
            $display("FAIL reset_bus: adr=%h dat=%h sel=%h, required 0/0/f", wb_if.wb_adr_o, wb_if.wb_dat_o, wb_if.wb_sel_o);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_status: busy=%b done=%b err=%b, required 0", busy, done, err);
        else n_pass++;
`ifdef SDWR_CRC16_EN
        n_checks++;
        if (crc !== 16'h0) $display("FAIL reset_crc: crc=%h, required 0000", crc);
        else n_pass++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_cnt;
        run_sector(32'h100, 0, 1);
        n_checks++;
        if (cap_adr.size() < 128 || cap_adr[0] !== 32'h100 || cap_dat[0] !== 32'h0302_0100)
            $display("FAIL basic_first: writes=%0d, required first adr 00000100 dat 03020100", cap_adr.size());
        else n_pass++;
        n_checks++;
        if (cap_adr.size() < 128 || cap_adr[127] !== 32'h2FC)
            $display("FAIL basic_last: writes=%0d, required last adr 000002fc", cap_adr.size());
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL basic_done_count: got %0d, required 1", done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL basic_busy_after: busy=%b, required 0", busy);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int d0;
        d0 = done_cnt;
        run_sector(32'h402, 1, 6);
        n_checks++;
        if (first_stall != 8) $display("FAIL bp_stall_point: ready first low after %0d bytes, required 8", first_stall);
        else n_pass++;
        n_checks++;
        if (cap_adr.size() < 1 || cap_adr[0] !== 32'h400)
            $display("FAIL bp_base_align: first adr wrong, required 00000400");
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL bp_done_count: got %0d, required 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int d0;
        d0 = done_cnt;
        run_sector(32'h1F00, 0, 1);
        n_checks++;
        if (cap_adr.size() < 65 || cap_adr[63] !== 32'h1FFC || cap_adr[64] !== 32'h0)
            $display("FAIL wrap_point: writes=%0d, required adr 00001ffc then 00000000", cap_adr.size());
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL wrap_done_count: got %0d, required 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_abort();
        int d0, e0, g;
        logic held;
        d0 = done_cnt; e0 = err_cnt;
        ack_delay = 4;
        @(negedge clk);
        start = 1'b1; base_adr = 32'h200;
        @(negedge clk);
        start = 1'b0; byte_valid = 1'b1; byte_dat = 8'h5A;
        g = 0;
        while (!wb_if.wb_cyc_o && g < 50) begin @(negedge clk); g++; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        held = 1'b1; g = 0;
        while (!(wb_if.wb_cyc_o && slv_ack) && g < 50) begin
            if (!wb_if.wb_stb_o) held = 1'b0;
            @(negedge clk);
            g++;
        end
        n_checks++;
        if (held !== 1'b1 || g >= 50) $display("FAIL abort_stb_held: held=%b waited=%0d, required held until ack", held, g);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || wb_if.wb_cyc_o !== 1'b0)
            $display("FAIL abort_err_pulse: err=%b busy=%b cyc=%b, required 1/0/0", err, busy, wb_if.wb_cyc_o);
        else n_pass++;
        @(negedge clk);
        byte_valid = 1'b0;
        n_checks++;
        if (err !== 1'b0 || byte_ready !== 1'b0 || wb_if.wb_cyc_o !== 1'b0)
            $display("FAIL abort_settled: err=%b ready=%b cyc=%b, required 0/0/0", err, byte_ready, wb_if.wb_cyc_o);
        else n_pass++;
        // abort with nothing on the bus ends the sector at once
        start = 1'b1; base_adr = 32'h300;
        @(negedge clk);
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) $display("FAIL abort_idle_bus: err=%b busy=%b, required 1/0", err, busy);
        else n_pass++;
        // abort in IDLE is ignored
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0) $display("FAIL abort_in_idle: err=%b busy=%b, required 0/0", err, busy);
        else n_pass++;
        // start beats a simultaneous abort in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || err !== 1'b0) $display("FAIL start_wins: busy=%b err=%b, required 1/0", busy, err);
        else n_pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (err_cnt - e0 != 3 || done_cnt != d0)
            $display("FAIL abort_pulse_counts: err=%0d done=%0d, required 3/0", err_cnt - e0, done_cnt - d0);
        else n_pass++;
        run_sector(32'h800, 1, 2);
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL abort_restart_done: got %0d, required 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int g;
        ack_delay = 6;
        @(negedge clk);
        start = 1'b1; base_adr = 32'h0;
        @(negedge clk);
        start = 1'b0; byte_valid = 1'b1; byte_dat = 8'hC3;
        g = 0;
        while (!wb_if.wb_cyc_o && g < 50) begin @(negedge clk); g++; end
        n_checks++;
        if (wb_if.wb_cyc_o !== 1'b1 || busy !== 1'b1)
            $display("FAIL rst_mid_setup: cyc=%b busy=%b, required 1/1", wb_if.wb_cyc_o, busy);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (wb_if.wb_cyc_o !== 1'b0 || wb_if.wb_stb_o !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0)
            $display("FAIL rst_mid_async: cyc=%b stb=%b busy=%b ready=%b, required 0", wb_if.wb_cyc_o, wb_if.wb_stb_o, busy, byte_ready);
        else n_pass++;
        byte_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (wb_if.wb_cyc_o !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_mid_after: cyc=%b busy=%b, required 0/0", wb_if.wb_cyc_o, busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        run_sector(32'h1000, 1, 1);
        run_sector(32'h1804, 0, 3);
        n_checks++;
        if (cap_adr.size() < 1 || cap_adr[0] !== 32'h1804 || cap_dat[0] !== 32'h0302_0100)
            $display("FAIL b2b_second_first: writes=%0d, required adr 00001804 dat 03020100", cap_adr.size());
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 2) $display("FAIL b2b_done_count: got %0d, required 2", done_cnt - d0);
        else n_pass++;
    endtask

`ifdef SDWR_CRC16_EN
    task automatic test_crc();
        run_sector(32'h0, 2, 1);
        n_checks++;
        if (crc !== 16'h7FA1) $display("FAIL crc_ff_sector: crc=%h, required 7fa1", crc);
        else n_pass++;
        @(negedge clk);
        start = 1'b1; base_adr = 32'h0;
        @(negedge clk);
        start = 1'b0; abort = 1'b1;
        n_checks++;
        if (crc !== 16'h0) $display("FAIL crc_clear_on_start: crc=%h, required 0000", crc);
        else n_pass++;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        byte_valid = 1'b0; byte_dat = 8'h0; base_adr = 32'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef SDWR_CRC16_EN
        test_crc();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
